// File: rtl/odd_pipe_param_pkg.sv
// ----------------------------------------------------------------------------
// odd_pipe_param_pkg
// Shared definitions for the odd-side result staging pipe.
//   - unit-id constants for the odd-side producers (perm / load-store / branch)
//   - packet field offsets and the packet-width helper
//   - bubble constant (an empty stage is all-zero)
// Packet layout, MSB first: {unit_id, result, reg_dst, latency, reg_wr}
// ----------------------------------------------------------------------------
package odd_pipe_param_pkg;

    typedef enum logic [2:0] {
        UNIT_NONE = 3'b000,
        UNIT_PERM = 3'b101,
        UNIT_LS   = 3'b110,
        UNIT_BR   = 3'b111
    } unit_id_e;

    // Fixed low-order fields; the rest depend on the configured widths.
    localparam int OFF_REG_WR  = 0;
    localparam int OFF_LATENCY = 1;

    function automatic int off_reg_dst(input int lat_w);
        return OFF_LATENCY + lat_w;
    endfunction

    function automatic int off_result(input int lat_w, input int addr_w);
        return OFF_LATENCY + lat_w + addr_w;
    endfunction

    function automatic int off_unit(input int lat_w, input int addr_w, input int data_w);
        return OFF_LATENCY + lat_w + addr_w + data_w;
    endfunction

    function automatic int pkt_width(input int unit_w, input int data_w,
                                     input int addr_w, input int lat_w);
        return unit_w + data_w + addr_w + lat_w + 1;
    endfunction

    // Wide enough for any sensible configuration; users slice [PKT_W-1:0].
    localparam int              MAX_PKT_W = 512;
    localparam logic [MAX_PKT_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/odd_pipe_param_if.sv
// ----------------------------------------------------------------------------
// odd_pipe_param_if
// Bundles the issue side, forwarding taps, writeback port and branch-resolution
// outputs of the odd-side staging pipe.
//   master : functional-unit / consumer side (drives issue + control)
//   slave  : the staging pipe itself
// Issue   : stall, flush, in_valid, in_unit_id, in_result, in_reg_dst,
//           in_latency, in_reg_wr, in_branch, in_br_taken, in_new_pc
// Forward : fwd_bus (stage1 at MSBs), fwd_ready (bit i = stage i+1)
// Wb      : wb_addr, wb_data, wb_en
// Branch  : br_valid, br_taken, br_pc
// Optional: perf_retired, perf_flushed when ODD_PIPE_PERF_EN is defined.
// ----------------------------------------------------------------------------
interface odd_pipe_param_if
    import odd_pipe_param_pkg::*;
#(
    parameter int DEPTH  = 7,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int UNIT_W = 3,
    parameter int LAT_W  = 4,
    parameter int PC_W   = 10
);
    localparam int PKT_W = pkt_width(UNIT_W, DATA_W, ADDR_W, LAT_W);

    logic                     stall;
    logic                     flush;
    logic                     in_valid;
    logic [UNIT_W-1:0]        in_unit_id;
    logic [DATA_W-1:0]        in_result;
    logic [ADDR_W-1:0]        in_reg_dst;
    logic [LAT_W-1:0]         in_latency;
    logic                     in_reg_wr;
    logic                     in_branch;
    logic                     in_br_taken;
    logic [PC_W-1:0]          in_new_pc;

    logic [DEPTH*PKT_W-1:0]   fwd_bus;
    logic [DEPTH-1:0]         fwd_ready;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     wb_en;
    logic                     br_valid;
    logic                     br_taken;
    logic [PC_W-1:0]          br_pc;
`ifdef ODD_PIPE_PERF_EN
    logic [31:0]              perf_retired;
    logic [31:0]              perf_flushed;
`endif

    modport master (
        output stall, flush, in_valid, in_unit_id, in_result, in_reg_dst,
               in_latency, in_reg_wr, in_branch, in_br_taken, in_new_pc,
        input  fwd_bus, fwd_ready, wb_addr, wb_data, wb_en,
               br_valid, br_taken, br_pc
`ifdef ODD_PIPE_PERF_EN
        , input perf_retired, perf_flushed
`endif
    );

    modport slave (
        input  stall, flush, in_valid, in_unit_id, in_result, in_reg_dst,
               in_latency, in_reg_wr, in_branch, in_br_taken, in_new_pc,
        output fwd_bus, fwd_ready, wb_addr, wb_data, wb_en,
               br_valid, br_taken, br_pc
`ifdef ODD_PIPE_PERF_EN
        , output perf_retired, perf_flushed
`endif
    );

endinterface

// File: rtl/odd_pipe_param_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// One staging register: a packet plus a valid flag.
//   clk, rst  : clock, asynchronous active-high reset
//   i_hold    : keep current contents
//   i_kill    : load a bubble (takes priority over hold)
//   i_valid   : valid flag to load
//   i_pkt     : packet to load
//   o_valid   : registered valid flag
//   o_pkt     : registered packet
// The valid flag travels alongside the packet so an all-zero but genuine
// packet can still be told apart from a bubble (needed for flush accounting).
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int PKT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hold,
    input  logic             i_kill,
    input  logic             i_valid,
    input  logic [PKT_W-1:0] i_pkt,
    output logic             o_valid,
    output logic [PKT_W-1:0] o_pkt
);
    logic             r_valid;
    logic [PKT_W-1:0] r_pkt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (i_kill) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_pkt   <= i_pkt;
        end
    end

    assign o_valid = r_valid;
    assign o_pkt   = r_pkt;

endmodule

// File: rtl/odd_pipe_param.sv
// ----------------------------------------------------------------------------
// odd_pipe_param
// Result-staging pipe for the odd execution side. Each issued packet is
// registered into stage1 and shifts through DEPTH stages to a registered
// register-file writeback port (writeback one cycle after stage DEPTH).
// Every stage is exposed to the forwarding unit with a per-stage ready flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : odd_pipe_param_if.slave (issue, forwarding, writeback, branch)
// Control:
//   stall    : freezes every stage and branch capture; writeback enable drops
//   flush    : drops the incoming packet and squashes stages 2..KILL_STAGES;
//              older stages keep shifting and writing back (flush beats stall)
// Build option: define ODD_PIPE_PERF_EN to add perf_retired / perf_flushed.
// ----------------------------------------------------------------------------
module odd_pipe_param
    import odd_pipe_param_pkg::*;
#(
    parameter int DEPTH       = 7,
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 7,
    parameter int UNIT_W      = 3,
    parameter int LAT_W       = 4,
    parameter int PC_W        = 10,
    parameter int KILL_STAGES = 1
) (
    input  logic           clk,
    input  logic           rst,
    odd_pipe_param_if.slave bus
);
    localparam int PKT_W   = pkt_width(UNIT_W, DATA_W, ADDR_W, LAT_W);
    localparam int OFF_DST = off_reg_dst(LAT_W);
    localparam int OFF_RES = off_result(LAT_W, ADDR_W);

    logic [PKT_W-1:0]       w_in_pkt;
    logic                   w_hold;
    logic                   w_br_cap;
    logic [PKT_W-1:0]       w_stage_pkt [DEPTH];
    logic [DEPTH-1:0]       w_stage_vld;
    logic [DEPTH-1:0]       w_fwd_ready;
    logic [DEPTH*PKT_W-1:0] w_fwd_bus;
    logic [PKT_W-1:0]       w_last;

    logic                   r_wb_en;
    logic [ADDR_W-1:0]      r_wb_addr;
    logic [DATA_W-1:0]      r_wb_data;
    logic                   r_br_valid;
    logic                   r_br_taken;
    logic [PC_W-1:0]        r_br_pc;

    assign w_in_pkt = {bus.in_unit_id, bus.in_result, bus.in_reg_dst,
                       bus.in_latency, bus.in_reg_wr};

    // Stall only freezes when no flush is pending; a flush always advances.
    assign w_hold   = bus.stall & ~bus.flush;
    assign w_br_cap = bus.in_valid & bus.in_branch & ~bus.stall & ~bus.flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [PKT_W-1:0] w_d_pkt;
            logic             w_d_vld;
            logic             w_kill;
            logic [LAT_W-1:0] w_lat;
            logic [LAT_W-1:0] w_eff_lat;

            if (gi == 0) begin : g_head
                assign w_d_vld = bus.in_valid;
                assign w_d_pkt = bus.in_valid ? w_in_pkt : BUBBLE[PKT_W-1:0];
                assign w_kill  = bus.flush;
            end else begin : g_body
                assign w_d_vld = w_stage_vld[gi-1];
                assign w_d_pkt = w_stage_pkt[gi-1];
                // Stage gi+1 is one of the squashed younger stages when gi+1 <= KILL_STAGES.
                assign w_kill  = bus.flush & (gi < KILL_STAGES);
            end

            pipe_stage_reg #(.PKT_W(PKT_W)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_hold  (w_hold),
                .i_kill  (w_kill),
                .i_valid (w_d_vld),
                .i_pkt   (w_d_pkt),
                .o_valid (w_stage_vld[gi]),
                .o_pkt   (w_stage_pkt[gi])
            );

            // Latency 0 behaves like 1. A latency beyond DEPTH can never be
            // <= a stage index, so such a result only shows up at writeback.
            assign w_lat       = w_stage_pkt[gi][OFF_LATENCY +: LAT_W];
            assign w_eff_lat   = (w_lat == '0) ? LAT_W'(1) : w_lat;
            assign w_fwd_ready[gi] = w_stage_vld[gi] & w_stage_pkt[gi][OFF_REG_WR]
                                   & (32'(w_eff_lat) <= 32'(gi + 1));
        end
    endgenerate

    // Stage1 occupies the most significant slice of the forwarding bus.
    always_comb begin
        w_fwd_bus = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_bus[(DEPTH-k)*PKT_W-1 -: PKT_W] = w_stage_pkt[k];
        end
    end

    assign w_last = w_stage_pkt[DEPTH-1];

    // Writeback: enable drops while stalled but address/data keep their value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_hold) begin
            r_wb_en   <= 1'b0;
        end else begin
            r_wb_en   <= w_last[OFF_REG_WR];
            r_wb_addr <= w_last[OFF_DST +: ADDR_W];
            r_wb_data <= w_last[OFF_RES +: DATA_W];
        end
    end

    // Branch resolution: single-cycle strobe, outcome and target held until the
    // next accepted branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_valid <= 1'b0;
            r_br_taken <= 1'b0;
            r_br_pc    <= '0;
        end else begin
            r_br_valid <= w_br_cap;
            if (w_br_cap) begin
                r_br_taken <= bus.in_br_taken;
                r_br_pc    <= bus.in_new_pc;
            end
        end
    end

    assign bus.fwd_bus   = w_fwd_bus;
    assign bus.fwd_ready = w_fwd_ready;
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_addr   = r_wb_addr;
    assign bus.wb_data   = r_wb_data;
    assign bus.br_valid  = r_br_valid;
    assign bus.br_taken  = r_br_taken;
    assign bus.br_pc     = r_br_pc;

`ifdef ODD_PIPE_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_flushed;
    logic [31:0] w_flush_kills;

    // Packets lost on a flush: the incoming one plus the contents of stages
    // 1..KILL_STAGES-1, which are overwritten by the bubbles loaded behind them.
    always_comb begin
        w_flush_kills = 32'(bus.in_valid);
        for (int j = 0; j < KILL_STAGES - 1; j++) begin
            w_flush_kills = w_flush_kills + 32'(w_stage_vld[j]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (r_wb_en) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (bus.flush) begin
                r_perf_flushed <= r_perf_flushed + w_flush_kills;
            end
        end
    end

    assign bus.perf_retired = r_perf_retired;
    assign bus.perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_odd_pipe_param.sv
// ----------------------------------------------------------------------------
// tb_odd_pipe_param
// Directed bench for odd_pipe_param (DEPTH=7, KILL_STAGES=2). Every packet that
// should write back is queued with its expected address, data and retire cycle;
// a negedge monitor pops and compares on each writeback.
// ----------------------------------------------------------------------------
module tb_odd_pipe_param;
    import odd_pipe_param_pkg::*;

    localparam int DEPTH  = 7;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 7;
    localparam int UNIT_W = 3;
    localparam int LAT_W  = 4;
    localparam int PC_W   = 10;
    localparam int KILL   = 2;
    localparam int PKT_W  = UNIT_W + DATA_W + ADDR_W + LAT_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    odd_pipe_param_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                        .UNIT_W(UNIT_W), .LAT_W(LAT_W), .PC_W(PC_W)) ifc ();

    odd_pipe_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                     .UNIT_W(UNIT_W), .LAT_W(LAT_W), .PC_W(PC_W),
                     .KILL_STAGES(KILL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                issue;
        int                due;
    } sb_t;

    sb_t               sb[$];
    sb_t               mon_e;
    logic [DEPTH-1:0]  exp_rdy;
    logic [DATA_W-1:0] d;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifc.stall = 1'b0;  ifc.flush = 1'b0;  ifc.in_valid = 1'b0;
        ifc.in_unit_id = '0; ifc.in_result = '0; ifc.in_reg_dst = '0;
        ifc.in_latency = '0; ifc.in_reg_wr = 1'b0;
        ifc.in_branch = 1'b0; ifc.in_br_taken = 1'b0; ifc.in_new_pc = '0;
    endtask

    task automatic set_pkt(input logic v, input logic [2:0] unit, input logic [DATA_W-1:0] data,
                           input logic [ADDR_W-1:0] dst, input logic [LAT_W-1:0] lat, input logic wr);
        ifc.in_valid = v; ifc.in_unit_id = unit; ifc.in_result = data;
        ifc.in_reg_dst = dst; ifc.in_latency = lat; ifc.in_reg_wr = wr;
    endtask

    task automatic set_br(input logic br, input logic taken, input logic [PC_W-1:0] pc);
        ifc.in_branch = br; ifc.in_br_taken = taken; ifc.in_new_pc = pc;
    endtask

    // Update the scoreboard for the edge about to happen, then advance one cycle.
    task automatic tick();
        if (ifc.flush) begin
            // Packets in stages 1..KILL-1 are squashed; the incoming one is never queued.
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].issue >= cyc - KILL + 2) sb.delete(i);
            end
        end else if (ifc.stall) begin
            for (int i = 0; i < sb.size(); i++) begin
                sb[i].issue++;
                sb[i].due++;
            end
        end else if (ifc.in_valid && ifc.in_reg_wr) begin
            sb.push_back('{addr: ifc.in_reg_dst, data: ifc.in_result,
                           issue: cyc + 1, due: cyc + 1 + DEPTH});
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.wb_en) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 160'(ifc.wb_en), 160'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("wb_addr", 160'(ifc.wb_addr), 160'(mon_e.addr));
                    chk("wb_data", 160'(ifc.wb_data), 160'(mon_e.data));
                    chk("wb_cycle", 160'(cyc), 160'(mon_e.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("wb_missing", 160'(ifc.wb_en), 160'(1));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wb_en",     160'(ifc.wb_en),     160'(0));
        chk("rst_wb_addr",   160'(ifc.wb_addr),   160'(0));
        chk("rst_wb_data",   160'(ifc.wb_data),   160'(0));
        chk("rst_br_valid",  160'(ifc.br_valid),  160'(0));
        chk("rst_br_pc",     160'(ifc.br_pc),     160'(0));
        chk("rst_fwd_ready", 160'(ifc.fwd_ready), 160'(0));
        chk("rst_fwd_bus",   160'(|ifc.fwd_bus),  160'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();

        // Single packet, latency 3: ready from stage 3 onwards, retires 8 cycles after issue.
        set_pkt(1'b1, UNIT_PERM, {16{8'hA5}}, 7'd5, 4'd3, 1'b1);
        tick(); idle();
        chk("single_s1_pkt", 160'(ifc.fwd_bus[DEPTH*PKT_W-1 -: PKT_W]),
            160'({UNIT_PERM, {16{8'hA5}}, 7'd5, 4'd3, 1'b1}));
        for (int k = 1; k <= DEPTH; k++) begin
            exp_rdy = (k >= 3) ? (7'd1 << (k - 1)) : 7'd0;
            chk($sformatf("single_rdy_s%0d", k), 160'(ifc.fwd_ready), 160'(exp_rdy));
            tick();
        end
        repeat (3) tick();

        // Latency 0 counts as 1, latency 9 is never forwardable, reg_wr=0 never ready.
        set_pkt(1'b1, UNIT_LS, 128'h11, 7'd1, 4'd0, 1'b1); tick();
        chk("lat0_rdy", 160'(ifc.fwd_ready), 160'(7'b0000001));
        set_pkt(1'b1, UNIT_LS, 128'h22, 7'd2, 4'd9, 1'b1); tick();
        chk("lat9_rdy", 160'(ifc.fwd_ready), 160'(7'b0000010));
        set_pkt(1'b1, UNIT_LS, 128'h33, 7'd3, 4'd1, 1'b0); tick();
        chk("nowr_rdy", 160'(ifc.fwd_ready), 160'(7'b0000100));
        idle();
        repeat (DEPTH + 3) tick();

        // Ten back-to-back packets retire on consecutive cycles in order.
        for (int i = 0; i < 10; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_pkt(1'b1, UNIT_PERM, d, 7'(10 + i), 4'd2, 1'b1);
            tick();
        end
        idle();
        repeat (DEPTH + 3) tick();

        // Fill the pipe, stall 3 cycles with a packet offered (must be ignored), resume.
        for (int i = 0; i < DEPTH; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_pkt(1'b1, UNIT_LS, d, 7'(40 + i), 4'd1, 1'b1);
            tick();
        end
        set_pkt(1'b1, UNIT_LS, 128'hDEAD, 7'd99, 4'd1, 1'b1);
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_wb_en_%0d", i), 160'(ifc.wb_en), 160'(0));
        end
        ifc.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_pkt(1'b1, UNIT_LS, d, 7'(60 + i), 4'd1, 1'b1);
            tick();
        end
        idle();
        repeat (DEPTH + 3) tick();

        // Flush (together with stall) drops the incoming packet and the stage1 one.
        set_pkt(1'b1, UNIT_PERM, 128'hA0, 7'd20, 4'd1, 1'b1); tick();
        set_pkt(1'b1, UNIT_PERM, 128'hA1, 7'd21, 4'd1, 1'b1); tick();
        set_pkt(1'b1, UNIT_PERM, 128'hA2, 7'd22, 4'd1, 1'b1); tick();
        idle(); tick();
        set_pkt(1'b1, UNIT_PERM, 128'hA3, 7'd23, 4'd1, 1'b1); tick();
        set_pkt(1'b1, UNIT_PERM, 128'hA4, 7'd24, 4'd1, 1'b1);
        ifc.flush = 1'b1; ifc.stall = 1'b1;
        tick(); idle();
        chk("flush_s1_bubble", 160'(ifc.fwd_bus[DEPTH*PKT_W-1 -: PKT_W]), 160'(0));
        chk("flush_rdy", 160'(ifc.fwd_ready), 160'(7'b0111000));
        repeat (DEPTH + 3) tick();

        // Branch capture: one-cycle strobe, held outcome, blocked by stall and flush.
        set_pkt(1'b1, UNIT_BR, 128'h1F4, 7'd9, 4'd1, 1'b1);
        set_br(1'b1, 1'b1, 10'h1F0);
        tick(); idle();
        chk("br_valid",      160'(ifc.br_valid), 160'(1));
        chk("br_taken",      160'(ifc.br_taken), 160'(1));
        chk("br_pc",         160'(ifc.br_pc),    160'(10'h1F0));
        tick();
        chk("br_valid_drop", 160'(ifc.br_valid), 160'(0));
        chk("br_pc_hold",    160'(ifc.br_pc),    160'(10'h1F0));
        set_pkt(1'b1, UNIT_BR, 128'h2E, 7'd8, 4'd1, 1'b1);
        set_br(1'b1, 1'b0, 10'h02A);
        ifc.stall = 1'b1;
        tick(); idle();
        chk("br_stall_valid", 160'(ifc.br_valid), 160'(0));
        chk("br_stall_taken", 160'(ifc.br_taken), 160'(1));
        chk("br_stall_pc",    160'(ifc.br_pc),    160'(10'h1F0));
        tick();
        set_pkt(1'b1, UNIT_BR, 128'h3C, 7'd7, 4'd1, 1'b1);
        set_br(1'b1, 1'b1, 10'h03C);
        ifc.flush = 1'b1;
        tick(); idle();
        chk("br_flush_valid", 160'(ifc.br_valid), 160'(0));
        set_pkt(1'b1, UNIT_BR, 128'h2A, 7'd6, 4'd1, 1'b1);
        set_br(1'b1, 1'b0, 10'h02A);
        tick(); idle();
        chk("br_nt_valid", 160'(ifc.br_valid), 160'(1));
        chk("br_nt_taken", 160'(ifc.br_taken), 160'(0));
        chk("br_nt_pc",    160'(ifc.br_pc),    160'(10'h02A));
        repeat (DEPTH + 3) tick();

        // Reset mid-stream while a writeback and a branch strobe are live.
        for (int i = 0; i < 9; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_pkt(1'b1, UNIT_PERM, d, 7'(80 + i), 4'd1, 1'b1);
            if (i == 8) set_br(1'b1, 1'b1, 10'h155);
            tick();
        end
        idle();
        chk("pre_rst_wb_en",    160'(ifc.wb_en),    160'(1));
        chk("pre_rst_br_valid", 160'(ifc.br_valid), 160'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wb_en",     160'(ifc.wb_en),     160'(0));
        chk("mid_rst_wb_addr",   160'(ifc.wb_addr),   160'(0));
        chk("mid_rst_wb_data",   160'(ifc.wb_data),   160'(0));
        chk("mid_rst_br_valid",  160'(ifc.br_valid),  160'(0));
        chk("mid_rst_br_pc",     160'(ifc.br_pc),     160'(0));
        chk("mid_rst_fwd_ready", 160'(ifc.fwd_ready), 160'(0));
        chk("mid_rst_fwd_bus",   160'(|ifc.fwd_bus),  160'(0));
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (DEPTH + 5) tick();

        chk("sb_drained", 160'(sb.size()), 160'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
